// File: rtl/pmem_burst_adaptor.sv
// pmem_burst_adaptor: turns one cache-line read/write into a BEATS-long burst on the memory bus
module pmem_burst_adaptor #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDR_WIDTH-1:0]  line_addr_i,
    input  logic                   line_read_i,
    input  logic                   line_write_i,
    input  logic [LINE_WIDTH-1:0]  line_wdata_i,
    output logic [LINE_WIDTH-1:0]  line_rdata_o,
    output logic                   line_resp_o,
    output logic [ADDR_WIDTH-1:0]  mem_addr_o,
    output logic                   mem_read_o,
    output logic                   mem_write_o,
    output logic [BURST_WIDTH-1:0] mem_wdata_o,
    input  logic [BURST_WIDTH-1:0] mem_rdata_i,
    input  logic                   mem_resp_i
);
    localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
    localparam int CW    = $clog2(BEATS);
    typedef enum logic [2:0] {IDLE, RD_BURST, RD_DONE, WR_BURST, WR_DONE} state_t;
    state_t                 r_state;
    logic [CW-1:0]          r_count;
    logic [LINE_WIDTH-1:0]  r_wbuf;
    logic                   w_last;
    logic [CW-1:0]          w_next;
    logic [ADDR_WIDTH-1:0]  w_addr;
    assign w_last = r_count == CW'(BEATS - 1);
    assign w_next = r_count + CW'(1);
    assign w_addr = line_addr_i & ~ADDR_WIDTH'(LINE_WIDTH / 8 - 1);
    // Burst sequencer; every bus-facing output is a register so nothing from line_* reaches mem_* combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_wbuf       <= '0;
            line_rdata_o <= '0;
            line_resp_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_read_o   <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_wdata_o  <= '0;
        end else begin
            line_resp_o <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_count <= '0;
                    if (line_write_i) begin
                        r_state     <= WR_BURST;
                        r_wbuf      <= line_wdata_i;
                        mem_wdata_o <= line_wdata_i[BURST_WIDTH-1:0];
                        mem_addr_o  <= w_addr;
                        mem_write_o <= 1'b1;
                    end else if (line_read_i) begin
                        r_state    <= RD_BURST;
                        mem_addr_o <= w_addr;
                        mem_read_o <= 1'b1;
                    end
                end
                RD_BURST: if (mem_resp_i) begin
                    line_rdata_o[r_count*BURST_WIDTH +: BURST_WIDTH] <= mem_rdata_i;
                    r_count <= w_next;
                    if (w_last) begin
                        r_state     <= RD_DONE;
                        mem_read_o  <= 1'b0;
                        line_resp_o <= 1'b1;
                    end
                end
                WR_BURST: if (mem_resp_i) begin
                    mem_wdata_o <= r_wbuf[w_next*BURST_WIDTH +: BURST_WIDTH];
                    r_count     <= w_next;
                    if (w_last) begin
                        r_state     <= WR_DONE;
                        mem_write_o <= 1'b0;
                        line_resp_o <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pmem_burst_adaptor.sv
// tb_pmem_burst_adaptor: directed vector table plus hand sequences for stalls and mid-burst reset
module tb_pmem_burst_adaptor;
    logic         clk, rst_n;
    logic [31:0]  line_addr_i;
    logic         line_read_i, line_write_i;
    logic [255:0] line_wdata_i, line_rdata_o;
    logic         line_resp_o;
    logic [31:0]  mem_addr_o;
    logic         mem_read_o, mem_write_o;
    logic [63:0]  mem_wdata_o, mem_rdata_i;
    logic         mem_resp_i;
    int n_tests = 0;
    int n_fail  = 0;

    pmem_burst_adaptor dut (
        .clk(clk), .rst_n(rst_n),
        .line_addr_i(line_addr_i), .line_read_i(line_read_i), .line_write_i(line_write_i),
        .line_wdata_i(line_wdata_i), .line_rdata_o(line_rdata_o), .line_resp_o(line_resp_o),
        .mem_addr_o(mem_addr_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_resp_i(mem_resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [63:0]  B1 = 64'h1111111111111111, B2 = 64'h2222222222222222;
    localparam logic [63:0]  B3 = 64'h3333333333333333, B4 = 64'h4444444444444444;
    localparam logic [255:0] RL = {B4, B3, B2, B1};
    localparam logic [63:0]  S0 = 64'h0F1E2D3C4B5ACDEF, S1 = 64'h1122334455667788;
    localparam logic [63:0]  S2 = 64'hDEADBEEFCAFEF00D, S3 = 64'h0123456789ABCDEF;
    localparam logic [255:0] W  = {S3, S2, S1, S0};

    typedef struct {
        logic rd, wr; logic [31:0] addr; logic [255:0] wd; logic mr; logic [63:0] md;
        logic e_rd, e_wr, e_resp; logic [31:0] e_addr; logic [63:0] e_wd; logic chk_rl;
    } vec_t;

    function automatic vec_t mk(input logic rd, wr, input logic [31:0] addr, input logic [255:0] wd,
                                input logic mr, input logic [63:0] md, input logic er, ew, ep,
                                input logic [31:0] ea, input logic [63:0] ewd, input logic cr);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wd = wd; v.mr = mr; v.md = md;
        v.e_rd = er; v.e_wr = ew; v.e_resp = ep; v.e_addr = ea; v.e_wd = ewd; v.chk_rl = cr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    vec_t vt[22];

    initial begin
        logic [63:0] sb[4];
        int pat[7];
        int k;
        vt[0]  = mk(1, 0, 32'h0000_1234, W,  0, 64'h0, 0, 0, 0, 32'h0,         64'h0, 0);
        vt[1]  = mk(0, 0, 32'h0000_1234, W,  1, B1,    1, 0, 0, 32'h0000_1220, 64'h0, 0);
        vt[2]  = mk(0, 0, 32'h0000_1234, W,  1, B2,    1, 0, 0, 32'h0000_1220, 64'h0, 0);
        vt[3]  = mk(0, 0, 32'h0000_1234, W,  1, B3,    1, 0, 0, 32'h0000_1220, 64'h0, 0);
        vt[4]  = mk(0, 0, 32'h0000_1234, W,  1, B4,    1, 0, 0, 32'h0000_1220, 64'h0, 0);
        vt[5]  = mk(0, 0, 32'h0000_1234, W,  0, 64'h0, 0, 0, 1, 32'h0,         64'h0, 1);
        vt[6]  = mk(0, 1, 32'h0000_8000, W,  0, 64'h0, 0, 0, 0, 32'h0,         64'h0, 0);
        vt[7]  = mk(0, 0, 32'h0000_9000, ~W, 1, 64'h0, 0, 1, 0, 32'h0000_8000, S0,    0);
        vt[8]  = mk(0, 0, 32'h0000_9000, ~W, 1, 64'h0, 0, 1, 0, 32'h0000_8000, S1,    0);
        vt[9]  = mk(0, 0, 32'h0000_9000, ~W, 1, 64'h0, 0, 1, 0, 32'h0000_8000, S2,    0);
        vt[10] = mk(0, 0, 32'h0000_9000, ~W, 1, 64'h0, 0, 1, 0, 32'h0000_8000, S3,    0);
        vt[11] = mk(0, 0, 32'h0000_9000, ~W, 0, 64'h0, 0, 0, 1, 32'h0,         64'h0, 1);
        vt[12] = mk(0, 0, 32'h0000_9000, ~W, 1, B4,    0, 0, 0, 32'h0,         64'h0, 1);
        vt[13] = mk(1, 1, 32'h0000_4040, W,  1, B3,    0, 0, 0, 32'h0,         64'h0, 1);
        vt[14] = mk(0, 0, 32'h0000_5555, ~W, 0, 64'h0, 0, 1, 0, 32'h0000_4040, S0,    0);
        vt[15] = mk(0, 0, 32'h0000_5555, ~W, 1, 64'h0, 0, 1, 0, 32'h0000_4040, S0,    0);
        vt[16] = mk(0, 0, 32'h0000_5555, ~W, 1, 64'h0, 0, 1, 0, 32'h0000_4040, S1,    0);
        vt[17] = mk(0, 0, 32'h0000_5555, ~W, 0, 64'h0, 0, 1, 0, 32'h0000_4040, S2,    0);
        vt[18] = mk(0, 0, 32'h0000_5555, ~W, 1, 64'h0, 0, 1, 0, 32'h0000_4040, S2,    0);
        vt[19] = mk(0, 0, 32'h0000_5555, ~W, 1, 64'h0, 0, 1, 0, 32'h0000_4040, S3,    0);
        vt[20] = mk(0, 0, 32'h0000_5555, ~W, 0, 64'h0, 0, 0, 1, 32'h0,         64'h0, 1);
        vt[21] = mk(0, 0, 32'h0000_5555, ~W, 0, 64'h0, 0, 0, 0, 32'h0,         64'h0, 1);

        rst_n = 1'b0; line_addr_i = '0; line_read_i = 0; line_write_i = 0;
        line_wdata_i = '0; mem_rdata_i = '0; mem_resp_i = 0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("reset mem_addr", mem_addr_o, 0);
        chk("reset mem_wdata", mem_wdata_o, 0);
        chk("reset line_rdata", line_rdata_o, 0);
        chk("reset ctl", {mem_read_o, mem_write_o, line_resp_o}, 0);
        next_cycle();
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            line_read_i = vt[i].rd; line_write_i = vt[i].wr; line_addr_i = vt[i].addr;
            line_wdata_i = vt[i].wd; mem_resp_i = vt[i].mr; mem_rdata_i = vt[i].md;
            @(negedge clk);
            chk($sformatf("v%0d mem_read", i), mem_read_o, vt[i].e_rd);
            chk($sformatf("v%0d mem_write", i), mem_write_o, vt[i].e_wr);
            chk($sformatf("v%0d line_resp", i), line_resp_o, vt[i].e_resp);
            if (vt[i].e_rd || vt[i].e_wr) chk($sformatf("v%0d mem_addr", i), mem_addr_o, vt[i].e_addr);
            if (vt[i].e_wr) chk($sformatf("v%0d mem_wdata", i), mem_wdata_o, vt[i].e_wd);
            if (vt[i].chk_rl) chk($sformatf("v%0d line_rdata", i), line_rdata_o, RL);
            next_cycle();
        end

        // read with stalled beats
        sb[0] = 64'hC1C1C1C1C1C1C1C1; sb[1] = 64'hC2C2C2C2C2C2C2C2;
        sb[2] = 64'hC3C3C3C3C3C3C3C3; sb[3] = 64'hC4C4C4C4C4C4C4C4;
        pat = '{1, 0, 0, 1, 1, 0, 1};
        line_read_i = 1; line_addr_i = 32'h0000_ABCD; mem_resp_i = 0;
        next_cycle();
        line_read_i = 0;
        k = 0;
        for (int j = 0; j < 7; j++) begin
            mem_resp_i = pat[j][0];
            mem_rdata_i = (pat[j] == 1) ? sb[k] : 64'hBADBADBADBADBAD0;
            @(negedge clk);
            chk($sformatf("stall%0d mem_read", j), mem_read_o, 1);
            chk($sformatf("stall%0d mem_addr", j), mem_addr_o, 32'h0000_ABC0);
            chk($sformatf("stall%0d line_resp", j), line_resp_o, 0);
            next_cycle();
            if (pat[j] == 1) k++;
        end
        mem_resp_i = 0;
        @(negedge clk);
        chk("stall resp", line_resp_o, 1);
        chk("stall read_drop", mem_read_o, 0);
        chk("stall line", line_rdata_o, {sb[3], sb[2], sb[1], sb[0]});
        next_cycle();
        @(negedge clk);
        chk("stall resp_single", line_resp_o, 0);
        next_cycle();

        // reset after two beats of a read
        line_read_i = 1; line_addr_i = 32'h0000_2000;
        next_cycle();
        line_read_i = 0;
        for (int j = 0; j < 2; j++) begin
            mem_resp_i = 1; mem_rdata_i = {8{8'hE1 + 8'(j)}};
            next_cycle();
        end
        mem_resp_i = 0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst mem_read", mem_read_o, 0);
        chk("arst mem_addr", mem_addr_o, 0);
        chk("arst line_rdata", line_rdata_o, 0);
        chk("arst mem_wdata", mem_wdata_o, 0);
        chk("arst resp_write", {line_resp_o, mem_write_o}, 0);
        for (int j = 0; j < 2; j++) begin
            mem_resp_i = 1;
            @(negedge clk);
            chk($sformatf("inrst%0d ctl", j), {mem_read_o, line_resp_o}, 0);
            next_cycle();
        end
        mem_resp_i = 0;
        rst_n = 1'b1;
        line_read_i = 1; line_addr_i = 32'h0000_3004;
        @(negedge clk);
        chk("post idle resp", line_resp_o, 0);
        next_cycle();
        line_read_i = 0;
        for (int j = 0; j < 4; j++) begin
            mem_resp_i = 1; mem_rdata_i = {8{8'hD1 + 8'(j)}};
            @(negedge clk);
            chk($sformatf("post%0d mem_read", j), mem_read_o, 1);
            chk($sformatf("post%0d resp", j), line_resp_o, 0);
            next_cycle();
        end
        mem_resp_i = 0;
        @(negedge clk);
        chk("post addr_hold", mem_addr_o, 32'h0000_3000);
        chk("post resp", line_resp_o, 1);
        chk("post line", line_rdata_o, {{8{8'hD4}}, {8{8'hD3}}, {8{8'hD2}}, {8{8'hD1}}});
        next_cycle();
        @(negedge clk);
        chk("post resp_single", line_resp_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pmem_burst_adaptor.md
# pmem_burst_adaptor

Converts single-line cache-side memory requests into multi-beat burst transactions on the physical-memory bus. Sits directly downstream of the cache controller's pmem port: accepts a full-line read or write (pmem_read/pmem_write, address, 256-bit line), runs the burst, and returns one pmem_resp pulse per completed line. Data is buffered internally so the cache can keep its datapath stable without per-beat involvement.

## Interface
- LINE_WIDTH, 256, cache line width in bits
- BURST_WIDTH, 64, memory bus beat width in bits; BEATS = LINE_WIDTH/BURST_WIDTH (power of two, ≥2)
- ADDR_WIDTH, 32, address width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- line_addr_i  in  ADDR_WIDTH  cache-side line address
- line_read_i  in  1  cache requests line fill
- line_write_i  in  1  cache requests line writeback
- line_wdata_i  in  LINE_WIDTH  line to write back
- line_rdata_o  out  LINE_WIDTH  assembled fill data
- line_resp_o  out  1  one-cycle completion pulse to cache
- mem_addr_o  out  ADDR_WIDTH  burst address, low log2(LINE_WIDTH/8) bits forced to 0
- mem_read_o  out  1  burst read request
- mem_write_o  out  1  burst write request
- mem_wdata_o  out  BURST_WIDTH  current write beat
- mem_rdata_i  in  BURST_WIDTH  current read beat
- mem_resp_i  in  1  beat accepted/valid strobe from memory

## Operation
- States: IDLE, RD_BURST, RD_DONE, WR_BURST, WR_DONE. Beat counter width log2(BEATS).
- IDLE: samples request. line_write_i has priority if both high. On request: latch address (and line_wdata_i for writes), clear counter, go RD_BURST/WR_BURST. mem_resp_i ignored in IDLE.
- RD_BURST: mem_read_o=1. Each cycle with mem_resp_i=1: store mem_rdata_i into buffer slice [count*BURST_WIDTH +: BURST_WIDTH], count++. Beats need not be consecutive; gaps hold state. On the beat where count==BEATS-1: go RD_DONE.
- RD_DONE: line_resp_o=1 for exactly one cycle, line_rdata_o = assembled line; next IDLE.
- WR_BURST: mem_write_o=1, mem_wdata_o = latched line slice [count]. Each mem_resp_i advances count; after beat BEATS-1 accepted go WR_DONE.
- WR_DONE: line_resp_o=1 one cycle; next IDLE.
- line_rdata_o is a register: holds last filled line until the next fill's beats overwrite it (valid only when qualified by line_resp_o after a read).
- Beat order: beat k = line bits [64k+63:64k], ascending, k=0 first.
- Request inputs are not re-sampled during a burst; changes to line_addr_i/line_wdata_i mid-burst have no effect.

## Timing
- Reset (async, rst_n=0): state IDLE, counter 0, mem_read_o=0, mem_write_o=0, line_resp_o=0, mem_addr_o=0, mem_wdata_o=0, line_rdata_o=0. Reset mid-burst aborts immediately; no resp issued.
- Request seen in IDLE at edge N: mem_read_o/mem_write_o and mem_addr_o valid from cycle N+1 (registered, no combinational path from line_*_i to mem_*_o).
- mem_read_o/mem_write_o stay high through the cycle of the last mem_resp_i, low the cycle after.
- Fill with back-to-back beats: request edge N, beats at N+1+d..N+4+d (d = memory latency) → line_resp_o at cycle N+5+d. Total = BEATS + d + 2 cycles.
- line_resp_o never asserted in two consecutive cycles. Upstream drops its request in the resp cycle; a request still high in the IDLE cycle after resp starts a new transaction (upstream's responsibility not to).
- Eviction-then-fill sequence from cache: WR_DONE → IDLE → RD_BURST; minimum one IDLE cycle between transactions.

## Test plan
- Read, back-to-back beats: addr 0x0000_1234, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 → mem_addr_o=0x0000_1220, one line_resp_o pulse, line_rdata_o = {0x44..44,0x33..33,0x22..22,0x11..11}.
- Read with stalls: mem_resp_i pattern 1,0,0,1,1,0,1 → same assembled line, resp one cycle after 4th beat, mem_read_o high throughout burst.
- Write: line_wdata_i = 256'h0123…CDEF, mem_resp_i held high → mem_wdata_o steps slice0..slice3 over 4 cycles, mem_write_o drops after beat 3, one resp.
- Evict-then-fill: write followed by read at different address → two resp pulses, at least one IDLE cycle between, mem_addr_o switches correctly, latched write data unaffected by line_wdata_i changes mid-burst.
- Simultaneous line_read_i and line_write_i → write burst only; spurious mem_resp_i in IDLE → no state change.
- rst_n asserted after beat 2 of a read → all outputs 0 asynchronously, no line_resp_o; subsequent read completes normally with counter from 0.
